// File: rtl/tulip_dsp_pkg.sv
// Shared definitions for the tulip DSP chain resamplers (interpolate, decimate, ...).
package tulip_dsp_pkg;

    // Phase counter width for a rate-N resampler; a rate of 1 still needs one bit.
    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interpolate_if.sv
// Streaming ports of the interpolator: sample input side and upsampled output side.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// a source holds valid (and its data) stable until that transfer, and ready may depend
// combinationally on the sink's own downstream ready.
interface interpolate_if #(
    parameter int DW = 24
) ();
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          hold_mode;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_first;

    // master: the environment (sample source and output sink)
    modport master (
        output din, din_valid, hold_mode, dout_ready,
        input  din_ready, dout, dout_valid, dout_first
    );

    // slave: the interpolator itself
    modport slave (
        input  din, din_valid, hold_mode, dout_ready,
        output din_ready, dout, dout_valid, dout_first
    );
endinterface

// File: rtl/interpolate.sv
// Integer-rate upsampler: each accepted sample becomes G_UPSAMPLE_RATE outputs,
// zero-stuffed or sample-held, with all data outputs driven from registers.
module interpolate
    import tulip_dsp_pkg::*;
#(
    parameter int G_DWIDTH        = 24,
    parameter int G_UPSAMPLE_RATE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    interpolate_if.slave bus,
    output logic [1:0]   o_dbg_state
);

    localparam int                PW         = phase_width(G_UPSAMPLE_RATE);
    localparam logic [PW-1:0]     LAST_PHASE = PW'(G_UPSAMPLE_RATE - 1);

    generate
        if (G_UPSAMPLE_RATE < 1 || G_UPSAMPLE_RATE > 65536) begin : g_bad_rate
            $error("interpolate: G_UPSAMPLE_RATE must be in 1..65536");
        end
    endgenerate

    typedef enum logic [1:0] {
        SM_INIT = 2'd0,
        SM_IDLE = 2'd1,
        SM_EMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [G_DWIDTH-1:0] r_hold;
    logic                r_hold_mode;
    logic [PW-1:0]       r_phase;
    logic [G_DWIDTH-1:0] r_dout;
    logic                r_dout_valid;
    logic                r_dout_first;

    logic w_flush;
    logic w_last;

    assign w_flush = reset | ~enable;
    assign w_last  = (r_phase == LAST_PHASE);

    // Ready on the last phase lets the next sample start with no bubble.
    assign bus.din_ready = ~w_flush &
                           ((r_state == SM_IDLE) |
                            ((r_state == SM_EMIT) & bus.dout_ready & w_last));

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_first = r_dout_first;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state      <= SM_INIT;
            r_hold       <= '0;
            r_hold_mode  <= 1'b0;
            r_phase      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
        end else begin
            case (r_state)
                SM_INIT: begin
                    r_state <= SM_IDLE;
                end

                SM_IDLE: begin
                    if (bus.din_valid) begin
                        r_hold       <= bus.din;
                        r_hold_mode  <= bus.hold_mode;
                        r_phase      <= '0;
                        r_dout       <= bus.din;
                        r_dout_valid <= 1'b1;
                        r_dout_first <= 1'b1;
                        r_state      <= SM_EMIT;
                    end
                end

                SM_EMIT: begin
                    // Nothing moves while downstream stalls.
                    if (bus.dout_ready) begin
                        if (!w_last) begin
                            r_phase      <= r_phase + PW'(1);
                            r_dout       <= r_hold_mode ? r_hold : '0;
                            r_dout_first <= 1'b0;
                        end else if (bus.din_valid) begin
                            r_hold       <= bus.din;
                            r_hold_mode  <= bus.hold_mode;
                            r_phase      <= '0;
                            r_dout       <= bus.din;
                            r_dout_first <= 1'b1;
                        end else begin
                            r_dout       <= '0;
                            r_dout_valid <= 1'b0;
                            r_dout_first <= 1'b0;
                            r_state      <= SM_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= SM_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interpolate.sv
// Directed bench for interpolate at rates 4, 3 and 1: cycle tables plus a scoreboarded stream.
module tb_interpolate;

    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en4, en3, en1;
    logic [1:0] st4, st3, st1;

    interpolate_if #(.DW(DW)) if4 ();
    interpolate_if #(.DW(DW)) if3 ();
    interpolate_if #(.DW(DW)) if1 ();

    interpolate #(.G_DWIDTH(DW), .G_UPSAMPLE_RATE(4)) u4 (
        .clk(clk), .reset(reset), .enable(en4), .bus(if4), .o_dbg_state(st4));
    interpolate #(.G_DWIDTH(DW), .G_UPSAMPLE_RATE(3)) u3 (
        .clk(clk), .reset(reset), .enable(en3), .bus(if3), .o_dbg_state(st3));
    interpolate #(.G_DWIDTH(DW), .G_UPSAMPLE_RATE(1)) u1 (
        .clk(clk), .reset(reset), .enable(en1), .bus(if1), .o_dbg_state(st1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One row = one clock cycle: inputs driven in it, outputs expected in it.
    typedef struct {
        logic          en;
        logic          dv;
        logic [DW-1:0] d;
        logic          hm;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ef;
        logic          er;
    } vec_t;

    function automatic vec_t v(input logic en, input logic dv, input logic [DW-1:0] d,
                               input logic hm, input logic rdy, input logic ev,
                               input logic [DW-1:0] ed, input logic ef, input logic er);
        vec_t r;
        r.en = en; r.dv = dv; r.d = d; r.hm = hm; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.ef = ef; r.er = er;
        return r;
    endfunction

    task automatic run4(input vec_t x, input int i);
        en4 = x.en; if4.din_valid = x.dv; if4.din = x.d;
        if4.hold_mode = x.hm; if4.dout_ready = x.rdy;
        #1;
        chk($sformatf("n4[%0d] dout_valid", i), DW'(if4.dout_valid), DW'(x.ev));
        chk($sformatf("n4[%0d] dout", i), if4.dout, x.ed);
        chk($sformatf("n4[%0d] dout_first", i), DW'(if4.dout_first), DW'(x.ef));
        chk($sformatf("n4[%0d] din_ready", i), DW'(if4.din_ready), DW'(x.er));
        @(posedge clk); #1;
    endtask

    task automatic run3(input vec_t x, input int i);
        en3 = x.en; if3.din_valid = x.dv; if3.din = x.d;
        if3.hold_mode = x.hm; if3.dout_ready = x.rdy;
        #1;
        chk($sformatf("n3[%0d] dout_valid", i), DW'(if3.dout_valid), DW'(x.ev));
        chk($sformatf("n3[%0d] dout", i), if3.dout, x.ed);
        chk($sformatf("n3[%0d] dout_first", i), DW'(if3.dout_first), DW'(x.ef));
        chk($sformatf("n3[%0d] din_ready", i), DW'(if3.din_ready), DW'(x.er));
        @(posedge clk); #1;
    endtask

    vec_t          t4[$];
    vec_t          t3[$];
    logic [DW-1:0] exp_q[$];

    initial begin
        int            sent;
        int            recv;
        int            cyc;
        logic [DW-1:0] cur;
        logic          cur_v;

        // Zero-stuff, sample-hold, hold_mode flip at phase 2, enable drop at phase 1.
        //                en dv d           hm rdy ev ed          ef er
        t4.push_back(v(1, 0, 24'h0,      0, 1,  0, 24'h0,      0, 0)); // INIT
        t4.push_back(v(1, 1, 24'h000011, 0, 1,  0, 24'h0,      0, 1));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h000011, 1, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 1, 24'h000022, 0, 1,  1, 24'h0,      0, 1)); // back-to-back
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h000022, 1, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 1));
        t4.push_back(v(1, 1, 24'h7FFFFF, 1, 1,  0, 24'h0,      0, 1)); // IDLE
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h7FFFFF, 1, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h7FFFFF, 0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h7FFFFF, 0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h7FFFFF, 0, 1));
        t4.push_back(v(1, 1, 24'hABCDEF, 0, 1,  0, 24'h0,      0, 1)); // IDLE
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'hABCDEF, 1, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      1, 1,  1, 24'h0,      0, 0)); // flip at phase 2
        t4.push_back(v(1, 1, 24'h123456, 1, 1,  1, 24'h0,      0, 1));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h123456, 1, 0));
        t4.push_back(v(0, 0, 24'h0,      0, 1,  1, 24'h123456, 0, 0)); // enable low at phase 1
        t4.push_back(v(0, 0, 24'h0,      0, 1,  0, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  0, 24'h0,      0, 0)); // INIT
        t4.push_back(v(1, 1, 24'h000055, 0, 1,  0, 24'h0,      0, 1)); // IDLE
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h000055, 1, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 1));
        t4.push_back(v(1, 0, 24'h0,      0, 1,  0, 24'h0,      0, 1));

        // Rate 3 under backpressure, starting from IDLE.
        t3.push_back(v(1, 1, 24'h0000A1, 0, 1,  0, 24'h0,      0, 1));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0000A1, 1, 0));
        t3.push_back(v(1, 0, 24'h0,      0, 0,  1, 24'h0,      0, 0));
        t3.push_back(v(1, 0, 24'h0,      0, 0,  1, 24'h0,      0, 0));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t3.push_back(v(1, 1, 24'h0000B2, 1, 1,  1, 24'h0,      0, 1));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 0,  1, 24'h0000B2, 1, 0));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 0,  1, 24'h0000B2, 1, 0));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 1,  1, 24'h0000B2, 1, 0));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 1,  1, 24'h0000B2, 0, 0));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 0,  1, 24'h0000B2, 0, 0));
        t3.push_back(v(1, 1, 24'h0000C3, 0, 1,  1, 24'h0000B2, 0, 1));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0000C3, 1, 0));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 0));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  1, 24'h0,      0, 1));
        t3.push_back(v(1, 0, 24'h0,      0, 1,  0, 24'h0,      0, 1));

        // Clock and reset.
        reset = 1'b1; en4 = 1'b1; en3 = 1'b1; en1 = 1'b1;
        if4.din_valid = 1'b0; if4.din = '0; if4.hold_mode = 1'b0; if4.dout_ready = 1'b1;
        if3.din_valid = 1'b0; if3.din = '0; if3.hold_mode = 1'b0; if3.dout_ready = 1'b1;
        if1.din_valid = 1'b0; if1.din = '0; if1.hold_mode = 1'b0; if1.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset n4 dout_valid", DW'(if4.dout_valid), '0);
        chk("reset n4 dout", if4.dout, '0);
        chk("reset n4 dout_first", DW'(if4.dout_first), '0);
        chk("reset n4 din_ready", DW'(if4.din_ready), '0);
        chk("reset n4 state", DW'(st4), '0);
        chk("reset n3 dout_valid", DW'(if3.dout_valid), '0);
        chk("reset n1 dout_valid", DW'(if1.dout_valid), '0);
        chk("reset n1 din_ready", DW'(if1.din_ready), '0);
        reset = 1'b0;

        foreach (t4[i]) run4(t4[i], i);
        foreach (t3[i]) run3(t3[i], i);

        // Rate 1: random stream under random downstream stalls must pass through unchanged.
        sent = 0; recv = 0; cyc = 0; cur = '0; cur_v = 1'b0;
        while ((sent < 100 || recv < 100) && cyc < 3000) begin
            if (!cur_v && sent < 100 && $urandom_range(0, 1) == 1) begin
                cur   = DW'($urandom);
                cur_v = 1'b1;
            end
            if1.din_valid  = cur_v;
            if1.din        = cur;
            if1.hold_mode  = 1'($urandom_range(0, 1));
            if1.dout_ready = 1'($urandom_range(0, 1));
            #1;
            if (if1.din_valid && if1.din_ready) begin
                exp_q.push_back(cur);
                sent++;
                cur_v = 1'b0;
            end
            if (if1.dout_valid && if1.dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL n1 spurious output: got %h expected no output", if1.dout);
                end else begin
                    chk($sformatf("n1 dout #%0d", recv), if1.dout, exp_q.pop_front());
                end
                chk($sformatf("n1 dout_first #%0d", recv), DW'(if1.dout_first), DW'(1));
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (recv != 100) begin
            errors++;
            $display("FAIL n1 stream count: got %0d expected 100", recv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
